// File: rtl/apb_uart_regs.sv
// APB3 completer for the UART register map: TXDATA / RXDATA / CTRL / STATUS,
// a small TX FIFO draining over valid/ready, programmable wait states and
// PSLVERR on illegal accesses.
module apb_uart_regs #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TX_DEPTH    = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            ctrl_out,
    output logic                  irq
);

    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    apb_state_t            state, state_nxt;
    logic [2:0]            wcnt;
    logic                  in_access, pready_i, complete;
    logic                  legal, err;
    logic [1:0]            reg_off;
    logic [DATA_WIDTH-1:0] rdata;

    logic [7:0]            ctrl;
    logic [7:0]            rx_buf;
    logic                  rx_full, overrun;

    logic [7:0]            tx_mem [TX_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         tx_count;
    logic                  tx_full, tx_empty, push, pop;
    logic [3:0]            cnt_sat;
    logic [7:0]            status;
    logic                  ctrl_wr, rx_rd, st_rd;

    // Only PWDATA[7:0] carries register data; the rest is deliberately ignored.
    logic                  unused_pwdata;
    assign unused_pwdata = ^PWDATA;

    // An access phase is only honoured after a setup phase was seen, so a
    // reset mid-transfer cannot complete the aborted access.
    assign in_access = PSEL & PENABLE & (state != IDLE);
    assign pready_i  = in_access & (wcnt == 3'(WAIT_STATES));
    assign complete  = pready_i;

    // Bus phase register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Bus phase sequencing from PSEL/PENABLE
    always_comb begin
        state_nxt = state;
        if (!PSEL)                state_nxt = IDLE;
        else if (!PENABLE)        state_nxt = SETUP;
        else if (complete)        state_nxt = IDLE;
        else if (state != IDLE)   state_nxt = ACCESS;
        else                      state_nxt = IDLE;
    end

    // Wait-state counter: counts stalled access cycles, clears on completion/deselect
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                 wcnt <= '0;
        else if (!PSEL || complete)   wcnt <= '0;
        else if (in_access)           wcnt <= wcnt + 3'd1;
    end

    // Address decode, error detection and read mux
    always_comb begin
        legal   = (PADDR[ADDR_WIDTH-1:4] == '0) && (PADDR[1:0] == 2'b00);
        reg_off = PADDR[3:2];
        err     = 1'b1;
        rdata   = '0;
        if (legal) begin
            case (reg_off)
                2'd0: err = PWRITE ? tx_full : 1'b1;
                2'd1: begin err = PWRITE; rdata = DATA_WIDTH'(rx_buf); end
                2'd2: begin err = 1'b0;   rdata = DATA_WIDTH'(ctrl);   end
                default: begin err = PWRITE; rdata = DATA_WIDTH'(status); end
            endcase
        end
    end

    // Bus outputs, gated so data/error only appear with PREADY
    always_comb begin
        PREADY  = pready_i;
        PSLVERR = pready_i & err;
        PRDATA  = (pready_i && !err && !PWRITE) ? rdata : '0;
    end

    assign push    = complete &  PWRITE & legal & (reg_off == 2'd0) & ~tx_full;
    assign ctrl_wr = complete &  PWRITE & legal & (reg_off == 2'd2);
    assign rx_rd   = complete & ~PWRITE & legal & (reg_off == 2'd1);
    assign st_rd   = complete & ~PWRITE & legal & (reg_off == 2'd3);

    assign tx_full  = (tx_count == CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_valid = ctrl[0] & ~tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem[rptr];
    assign pop      = tx_valid & tx_ready;

    // Status byte with saturated TX occupancy
    always_comb begin
        if (32'(tx_count) > 32'd15) cnt_sat = 4'hF;
        else                        cnt_sat = 4'(tx_count);
        status = {cnt_sat, overrun, rx_full, tx_empty, tx_full};
    end

    // TX FIFO storage and pointers; full is sampled before the edge
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
            wptr     <= '0;
            rptr     <= '0;
            tx_count <= '0;
        end else begin
            if (push) begin
                tx_mem[wptr] <= PWDATA[7:0];
                wptr         <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // CTRL register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)     ctrl <= '0;
        else if (ctrl_wr) ctrl <= PWDATA[7:0];
    end

    // RX holding buffer, full and overrun flags
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_buf  <= '0;
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_buf  <= rx_data;
                rx_full <= 1'b1;
            end else if (rx_rd) begin
                rx_full <= 1'b0;
            end
            // A fresh overrun outranks a STATUS read clearing the old one.
            if (rx_valid && rx_full && !rx_rd) overrun <= 1'b1;
            else if (st_rd)                    overrun <= 1'b0;
        end
    end

    assign ctrl_out = ctrl;
    assign irq      = (ctrl[1] & rx_full) | (ctrl[2] & tx_empty);

endmodule

// File: tb/tb_apb_uart_regs.sv
// Scoreboard bench for apb_uart_regs: expected APB completions are queued as
// each transfer is driven and compared when PREADY completes it.
module tb_apb_uart_regs;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned WS = 1;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic [7:0]    tx_data, rx_data, ctrl_out;
    logic          tx_valid, tx_ready, rx_valid, irq;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        bit          chk_rd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] txq[$];
    int         n_vec = 0;
    int         n_err = 0;

    apb_uart_regs #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS),
        .TX_DEPTH   (4)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .ctrl_out(ctrl_out),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every completed transfer
    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
                if (e.chk_rd) check("prdata", PRDATA, e.rd);
            end
        end
    end

    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_err,
                       input bit rx_at_done, input logic [7:0] rx_byte);
        int waits;
        exp_t e;
        e.rd = exp_rd; e.err = exp_err; e.chk_rd = !wr;
        sb.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        forever begin
            @(negedge PCLK);
            if (PREADY) break;
            check("prdata_wait", PRDATA, 32'd0);
            check("pslverr_wait", {31'd0, PSLVERR}, 32'd0);
            waits++;
            if (waits > 20) begin
                check("pready_timeout", 32'd1, 32'd0);
                break;
            end
        end
        check("wait_states", waits, WS);
        if (rx_at_done) begin
            rx_valid = 1'b1;
            rx_data  = rx_byte;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data, input bit exp_err);
        apb(1'b1, addr, data, 32'd0, exp_err, 1'b0, 8'd0);
    endtask

    task automatic rd32(input logic [31:0] addr, input logic [31:0] exp, input bit exp_err);
        apb(1'b0, addr, 32'd0, exp, exp_err, 1'b0, 8'd0);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(posedge PCLK); #1;
        rx_valid = 1'b1; rx_data = b;
        @(posedge PCLK); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5; bytes[1] = 8'h11; bytes[2] = 8'h22; bytes[3] = 8'h33;

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready",  {31'd0, PREADY},  32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_prdata",  PRDATA,           32'd0);
        check("rst_txvalid", {31'd0, tx_valid}, 32'd0);
        check("rst_txdata",  {24'd0, tx_data},  32'd0);
        check("rst_ctrl",    {24'd0, ctrl_out}, 32'd0);
        check("rst_irq",     {31'd0, irq},      32'd0);
        PRESETn = 1'b1;

        // CTRL write/read; tx_irq_en with an empty FIFO raises irq
        wr32(32'h08, 32'h05, 1'b0);
        check("ctrl_out", {24'd0, ctrl_out}, 32'h05);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        rd32(32'h08, 32'h05, 1'b0);
        wr32(32'h08, 32'h00, 1'b0);
        check("irq_off", {31'd0, irq}, 32'd0);

        // Fill the FIFO with the transmitter disabled; the 5th push is refused
        for (int i = 0; i < 4; i++) begin
            wr32(32'h00, {24'd0, bytes[i]}, 1'b0);
            txq.push_back(bytes[i]);
        end
        wr32(32'h00, 32'h44, 1'b1);
        rd32(32'h0C, 32'h41, 1'b0);
        check("txvalid_disabled", {31'd0, tx_valid}, 32'd0);

        // Enable and drain
        wr32(32'h08, 32'h01, 1'b0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("drain_valid", {31'd0, tx_valid}, 32'd1);
            if (txq.size() > 0) check("drain_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
        end
        @(negedge PCLK);
        check("drain_done", {31'd0, tx_valid}, 32'd0);
        check("drain_data0", {24'd0, tx_data}, 32'd0);
        #1 tx_ready = 1'b0;
        rd32(32'h0C, 32'h02, 1'b0);

        // RX overrun; the TX FIFO is empty so bit1 accompanies the RX bits
        rx_pulse(8'h3C);
        rx_pulse(8'h7E);
        rd32(32'h0C, 32'h0E, 1'b0);
        rd32(32'h0C, 32'h06, 1'b0);
        rd32(32'h04, 32'h7E, 1'b0);
        rd32(32'h0C, 32'h02, 1'b0);

        // RXDATA read completing on the same edge as a new byte
        wr32(32'h08, 32'h02, 1'b0);
        rx_pulse(8'h55);
        check("irq_rx", {31'd0, irq}, 32'd1);
        apb(1'b0, 32'h04, 32'd0, 32'h55, 1'b0, 1'b1, 8'h99);
        rd32(32'h0C, 32'h06, 1'b0);
        rd32(32'h04, 32'h99, 1'b0);
        check("irq_rx_clr", {31'd0, irq}, 32'd0);

        // Illegal accesses: error, no data, no side effects
        rd32(32'h10, 32'h0, 1'b1);
        wr32(32'h10, 32'hFF, 1'b1);
        wr32(32'h02, 32'hFF, 1'b1);
        wr32(32'h0C, 32'hFF, 1'b1);
        wr32(32'h04, 32'hFF, 1'b1);
        rd32(32'h00, 32'h0, 1'b1);
        rd32(32'h09, 32'h0, 1'b1);
        rd32(32'h0C, 32'h02, 1'b0);
        check("ctrl_kept", {24'd0, ctrl_out}, 32'h02);

        // Reset during the wait cycle of a TXDATA write
        wr32(32'h00, 32'h77, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h88;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_wait", {31'd0, PREADY}, 32'd0);
        PRESETn = 1'b0;
        #1;
        check("abort_pready", {31'd0, PREADY}, 32'd0);
        check("abort_ctrl",   {24'd0, ctrl_out}, 32'd0);
        check("abort_txdata", {24'd0, tx_data}, 32'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        rd32(32'h0C, 32'h02, 1'b0);
        wr32(32'h08, 32'h01, 1'b0);
        check("abort_no_push", {31'd0, tx_valid}, 32'd0);

        repeat (2) @(posedge PCLK);
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
